// File: rtl/pipe_share_arbiter_if.sv
// Requester, shared-unit and response signals of pipe_share_arbiter.
// slave = arbiter view, master = requester/shared-unit environment view.
interface pipe_share_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int REQS  = 4
);
    logic                    issue_en;
    logic [REQS-1:0]         req_valid;
    logic [REQS-1:0]         req_ready;
    logic [REQS*WIDTH-1:0]   req_data;
    logic                    pipe_valid;
    logic [WIDTH-1:0]        pipe_sink;
    logic [WIDTH-1:0]        pipe_source;
    logic [REQS-1:0]         rsp_valid;
    logic [WIDTH-1:0]        rsp_data;

    modport slave (
        input  issue_en, req_valid, req_data, pipe_source,
        output req_ready, pipe_valid, pipe_sink, rsp_valid, rsp_data
    );

    modport master (
        output issue_en, req_valid, req_data, pipe_source,
        input  req_ready, pipe_valid, pipe_sink, rsp_valid, rsp_data
    );
endinterface

// File: rtl/pipe_share_arbiter.sv
// Round-robin sharing of one fixed-latency pipelined unit among REQS requesters.
// Optional PIPE_SHARE_ARBITER_STATS_EN adds a saturating issue_count output.
module pipe_share_arbiter #(
    parameter int WIDTH   = 8,
    parameter int REQS    = 4,
    parameter int LATENCY = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    pipe_share_arbiter_if.slave  bus
`ifdef PIPE_SHARE_ARBITER_STATS_EN
    ,
    output logic [31:0]          issue_count
`endif
);
    localparam int ID_W = $clog2(REQS);

    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [REQS-1:0]  grant;
    logic [ID_W-1:0]  grant_id;
    logic             grant_any;
    int               idx;

    logic             pipe_valid_q;
    logic [WIDTH-1:0] pipe_sink_q, pipe_sink_d;
    logic [ID_W-1:0]  issue_id_q;

    logic [LATENCY-1:0] tag_v_q;
    logic [ID_W-1:0]    tag_id_q [LATENCY];

    logic [REQS-1:0]  rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        idx       = 0;
        if (bus.issue_en && !reset) begin
            for (int k = 1; k <= REQS; k++) begin
                idx = (int'(ptr_q) + k) % REQS;
                if (!grant_any && bus.req_valid[idx]) begin
                    grant_any   = 1'b1;
                    grant[idx]  = 1'b1;
                    grant_id    = ID_W'(idx);
                end
            end
        end
    end

    always_comb begin
        ptr_d       = grant_any ? grant_id : ptr_q;
        pipe_sink_d = grant_any ? bus.req_data[int'(grant_id)*WIDTH +: WIDTH] : pipe_sink_q;
    end

    always_comb begin
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        if (tag_v_q[LATENCY-1]) begin
            rsp_valid_d[tag_id_q[LATENCY-1]] = 1'b1;
            rsp_data_d                       = bus.pipe_source;
        end
    end

    // Tags shift unconditionally: the shared unit never stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q        <= ID_W'(REQS-1);
            pipe_valid_q <= 1'b0;
            pipe_sink_q  <= '0;
            issue_id_q   <= '0;
            tag_v_q      <= '0;
            for (int i = 0; i < LATENCY; i++) tag_id_q[i] <= '0;
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
        end else begin
            ptr_q        <= ptr_d;
            pipe_valid_q <= grant_any;
            pipe_sink_q  <= pipe_sink_d;
            issue_id_q   <= grant_id;
            tag_v_q[0]   <= pipe_valid_q;
            tag_id_q[0]  <= issue_id_q;
            for (int i = 1; i < LATENCY; i++) begin
                tag_v_q[i]  <= tag_v_q[i-1];
                tag_id_q[i] <= tag_id_q[i-1];
            end
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    assign bus.req_ready  = grant;
    assign bus.pipe_valid = pipe_valid_q;
    assign bus.pipe_sink  = pipe_sink_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_data   = rsp_data_q;

`ifdef PIPE_SHARE_ARBITER_STATS_EN
    logic [31:0] issue_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            issue_count_q <= '0;
        end else if (grant_any && (issue_count_q != 32'hFFFF_FFFF)) begin
            issue_count_q <= issue_count_q + 32'd1;
        end
    end

    assign issue_count = issue_count_q;
`endif
endmodule

// File: tb/tb_pipe_share_arbiter.sv
// Self-checking bench for pipe_share_arbiter: directed literal cases plus a
// randomized phase compared every cycle against a cycle-indexed expectation model.
module tb_pipe_share_arbiter;
    localparam int WIDTH   = 8;
    localparam int REQS    = 4;
    localparam int LATENCY = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic mon_en = 1'b0;
    always #5 clk = ~clk;

    pipe_share_arbiter_if #(.WIDTH(WIDTH), .REQS(REQS)) bus ();

`ifdef PIPE_SHARE_ARBITER_STATS_EN
    logic [31:0] issue_count;
`endif

    pipe_share_arbiter #(.WIDTH(WIDTH), .REQS(REQS), .LATENCY(LATENCY)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef PIPE_SHARE_ARBITER_STATS_EN
        ,
        .issue_count (issue_count)
`endif
    );

    // Shared unit: plain LATENCY-deep delay line on the common reset.
    logic [WIDTH-1:0] dl [LATENCY];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) dl[i] <= '0;
        end else begin
            dl[0] <= bus.pipe_sink;
            for (int i = 1; i < LATENCY; i++) dl[i] <= dl[i-1];
        end
    end
    assign bus.pipe_source = dl[LATENCY-1];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expectation model: everything keyed by the cycle following each edge.
    int cyc = 0;
    int mptr;
    int exp_pv_id [int];
    logic [WIDTH-1:0] exp_pv_dat [int];
    int exp_rsp_id [int];
    logic [WIDTH-1:0] exp_rsp_dat [int];
    logic [WIDTH-1:0] last_rsp;
    longint exp_cnt;

    function automatic int model_grant();
        if (reset || !bus.issue_en) return -1;
        for (int k = 1; k <= REQS; k++) begin
            int j;
            j = (mptr + k) % REQS;
            if (bus.req_valid[j]) return j;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        int g;
        cyc++;
        g = model_grant();
        if (reset) begin
            mptr = REQS - 1;
            exp_pv_id.delete();
            exp_pv_dat.delete();
            exp_rsp_id.delete();
            exp_rsp_dat.delete();
            last_rsp = '0;
            exp_cnt = 0;
        end else begin
            if (g >= 0) begin
                mptr = g;
                exp_pv_id[cyc]  = g;
                exp_pv_dat[cyc] = bus.req_data[g*WIDTH +: WIDTH];
                exp_rsp_id[cyc+LATENCY+1]  = g;
                exp_rsp_dat[cyc+LATENCY+1] = bus.req_data[g*WIDTH +: WIDTH];
                if (exp_cnt < 64'h0000_0000_FFFF_FFFF) exp_cnt++;
            end
            if (exp_rsp_id.exists(cyc)) last_rsp = exp_rsp_dat[cyc];
        end
    end

    always @(negedge clk) begin
        int g;
        logic [REQS-1:0] er;
        logic [REQS-1:0] erv;
        if (mon_en) begin
            g = model_grant();
            er = '0;
            if (g >= 0) er[g] = 1'b1;
            chk("req_ready", bus.req_ready, er);
            chk("pipe_valid", bus.pipe_valid, exp_pv_id.exists(cyc));
            if (exp_pv_id.exists(cyc)) chk("pipe_sink", bus.pipe_sink, exp_pv_dat[cyc]);
            erv = '0;
            if (exp_rsp_id.exists(cyc)) erv[exp_rsp_id[cyc]] = 1'b1;
            chk("rsp_valid", bus.rsp_valid, erv);
            chk("rsp_data", bus.rsp_data, last_rsp);
`ifdef PIPE_SHARE_ARBITER_STATS_EN
            chk("issue_count", issue_count, exp_cnt[31:0]);
`endif
            if (exp_pv_id.exists(cyc)) begin
                exp_pv_id.delete(cyc);
                exp_pv_dat.delete(cyc);
            end
            if (exp_rsp_id.exists(cyc)) begin
                exp_rsp_id.delete(cyc);
                exp_rsp_dat.delete(cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    logic [REQS-1:0]  grants [6];
    logic [WIDTH-1:0] rq_dat [$];
    logic [REQS-1:0]  rq_vld [$];
    logic [REQS-1:0]  rdy_s;
    int cnt;

    initial begin
        bus.issue_en  = 1'b1;
        bus.req_valid = '1;
        bus.req_data  = '0;
        repeat (3) tick();
        mon_en = 1'b1;

        // Reset values, with requests pending during reset.
        @(negedge clk);
        chk("rst_req_ready", bus.req_ready, 4'b0000);
        chk("rst_pipe_valid", bus.pipe_valid, 1'b0);
        chk("rst_pipe_sink", bus.pipe_sink, 8'h00);
        chk("rst_rsp_valid", bus.rsp_valid, 4'b0000);
        chk("rst_rsp_data", bus.rsp_data, 8'h00);
        tick();
        reset = 1'b0;
        bus.req_valid = '0;

        // Single request from 2, data 5A.
        bus.req_valid = 4'b0100;
        bus.req_data[2*WIDTH +: WIDTH] = 8'h5A;
        @(negedge clk);
        chk("t1_ready", bus.req_ready, 4'b0100);
        tick();
        bus.req_valid = '0;
        @(negedge clk);
        chk("t1_pipe_valid", bus.pipe_valid, 1'b1);
        chk("t1_pipe_sink", bus.pipe_sink, 8'h5A);
        repeat (3) tick();
        @(negedge clk);
        chk("t1_rsp_early", bus.rsp_valid, 4'b0000);
        tick();
        @(negedge clk);
        chk("t1_rsp_valid", bus.rsp_valid, 4'b0100);
        chk("t1_rsp_data", bus.rsp_data, 8'h5A);

        // All four continuously valid: rotation 0,1,2,3,0,1.
        do_reset();
        for (int i = 0; i < REQS; i++) bus.req_data[i*WIDTH +: WIDTH] = 8'(8'h10 + i);
        bus.req_valid = 4'b1111;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (i < 6) grants[i] = bus.req_ready;
            if (bus.rsp_valid != '0) begin
                rq_dat.push_back(bus.rsp_data);
                rq_vld.push_back(bus.rsp_valid);
            end
            tick();
            if (i == 5) bus.req_valid = '0;
        end
        for (int i = 0; i < 6; i++) chk("t2_grant", grants[i], 4'b0001 << (i % 4));
        chk("t2_rsp_count", rq_dat.size(), 6);
        for (int i = 0; i < 6 && i < rq_dat.size(); i++) begin
            chk("t2_rsp_valid", rq_vld[i], 4'b0001 << (i % 4));
            chk("t2_rsp_data", rq_dat[i], 8'h10 + (i % 4));
        end

        // issue_en low blocks grants; then 1 before 3.
        do_reset();
        bus.req_data[1*WIDTH +: WIDTH] = 8'h21;
        bus.req_data[3*WIDTH +: WIDTH] = 8'h23;
        bus.req_valid = 4'b1010;
        bus.issue_en  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_ready_blocked", bus.req_ready, 4'b0000);
            tick();
        end
        bus.issue_en = 1'b1;
        @(negedge clk);
        chk("t3_first", bus.req_ready, 4'b0010);
        tick();
        bus.req_valid = 4'b1000;
        @(negedge clk);
        chk("t3_second", bus.req_ready, 4'b1000);
        tick();
        bus.req_valid = '0;
        @(negedge clk);
        chk("t3_no_rsp", bus.rsp_valid, 4'b0000);
        repeat (3) tick();
        @(negedge clk);
        chk("t3_rsp1_valid", bus.rsp_valid, 4'b0010);
        chk("t3_rsp1_data", bus.rsp_data, 8'h21);
        tick();
        @(negedge clk);
        chk("t3_rsp3_valid", bus.rsp_valid, 4'b1000);
        chk("t3_rsp3_data", bus.rsp_data, 8'h23);

        // Reset with three items in flight drops all of them.
        do_reset();
        bus.req_valid = 4'b0010;
        bus.req_data[1*WIDTH +: WIDTH] = 8'h31;
        tick();
        bus.req_data[1*WIDTH +: WIDTH] = 8'h32;
        tick();
        bus.req_data[1*WIDTH +: WIDTH] = 8'h33;
        tick();
        bus.req_valid = '0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t4_dropped", bus.rsp_valid, 4'b0000);
            tick();
        end
        bus.req_data[0*WIDTH +: WIDTH] = 8'h41;
        bus.req_data[2*WIDTH +: WIDTH] = 8'h43;
        bus.req_valid = 4'b0101;
        @(negedge clk);
        chk("t4_ptr_reset", bus.req_ready, 4'b0001);
        tick();
        bus.req_valid = '0;
        repeat (6) tick();

        // Lone requester 3 granted every cycle.
        cnt = 0;
        bus.req_valid = 4'b1000;
        bus.req_data[3*WIDTH +: WIDTH] = 8'h50;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t5_ready", bus.req_ready, 4'b1000);
            if (bus.rsp_valid == 4'b1000) cnt++;
            tick();
            bus.req_data[3*WIDTH +: WIDTH] = 8'(8'h51 + i);
        end
        bus.req_valid = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.rsp_valid == 4'b1000) cnt++;
            tick();
        end
        chk("t5_rsp_count", cnt, 5);

`ifdef PIPE_SHARE_ARBITER_STATS_EN
        do_reset();
        bus.req_valid = 4'b0001;
        repeat (7) tick();
        bus.req_valid = '0;
        @(negedge clk);
        chk("stats_seven", issue_count, 32'd7);
        tick();
`endif

        // Randomized traffic with occasional reset and issue_en drops.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            rdy_s = bus.req_ready;
            tick();
            reset = ($urandom_range(0, 299) == 0);
            bus.issue_en = ($urandom_range(0, 9) != 0);
            for (int i = 0; i < REQS; i++) begin
                if (!bus.req_valid[i] || rdy_s[i]) begin
                    bus.req_valid[i] = ($urandom_range(0, 2) != 0);
                    bus.req_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
                end
            end
        end
        reset = 1'b0;
        bus.req_valid = '0;
        repeat (LATENCY + 4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
